wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin Wishbone B4 (pipelined) arbiter sharing the CPU's single bus master port between several internal requesters: instruction fetch, load/store and, later, DMA. It sits between the requesters' `o_wb_*` bundles and the SoC interconnect. It holds ownership for a whole `cyc` cycle, routes `ack`/`stall` to the owner only, and aborts stuck cycles with a watchdog.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: cycles without `ack` before abort; 0 disables the watchdog.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `i_m_cyc` in N_REQ: per-requester `cyc`.
- `i_m_stb` in N_REQ: per-requester `stb`.
- `i_m_we` in N_REQ: per-requester `we`.
- `i_m_addr` in N_REQ*ADDR_W: packed addresses; requester k at bits [k*ADDR_W +: ADDR_W].
- `i_m_data` in N_REQ*DATA_W: packed write data, same packing.
- `o_m_ack` out N_REQ: `ack` routed to the owner.
- `o_m_stall` out N_REQ: `stall` to each requester.
- `o_m_err` out N_REQ: one-cycle watchdog abort pulse to the owner.
- `o_m_data` out DATA_W: read data, broadcast to all requesters.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1: slave-side strobes.
- `o_wb_addr` out ADDR_W: slave-side address.
- `o_wb_data` out DATA_W: slave-side write data.
- `i_wb_ack`, `i_wb_stall` in 1: slave-side handshake.
- `i_wb_data` in DATA_W: slave-side read data.
- `o_grant` out N_REQ: registered one-hot owner, all-zero when idle.

## Operation
- States are IDLE and BUSY. State, `owner`, `last_owner`, `o_grant` and the watchdog counter are registered. The bus muxing is combinational from `owner`.
- IDLE:
  - If any `i_m_cyc` is high, grant the first requesting index scanning `last_owner+1, last_owner+2, …` modulo N_REQ.
  - Load `owner`, set `o_grant`, clear the watchdog and go to BUSY.
- BUSY:
  - `o_wb_cyc = i_m_cyc[owner]`.
  - `o_wb_stb = i_m_cyc[owner] & i_m_stb[owner]`.
  - `o_wb_we`, `o_wb_addr` and `o_wb_data` come from the owner's slice.
  - `o_m_ack[owner] = i_wb_ack`; `o_m_stall[owner] = i_wb_stall`.
  - Every non-owner sees `stall=1` and `ack=0`.
- In IDLE: all `o_wb_*` are 0, all `o_m_ack` are 0, and all `o_m_stall` are 1.
- `o_m_data = i_wb_data` at all times.
- Release: when the owner's `i_m_cyc` is sampled low in BUSY, set `last_owner = owner`, clear `o_grant` and go to IDLE.
- Watchdog (TIMEOUT>0), active in BUSY only:
  - The counter is cleared on grant and on every `i_wb_ack`, and increments otherwise, saturating.
  - When it reaches TIMEOUT with the owner's `cyc` still high, pulse `o_m_err[owner]` for exactly one cycle and force `o_wb_cyc`/`o_wb_stb` low in that cycle.
  - In the same cycle, set `last_owner = owner` and go to IDLE.
  - The aborted requester must drop `cyc`. If it keeps `cyc` high, it re-enters arbitration normally, behind the other requesters.
- An `i_wb_ack` arriving in IDLE, or in the abort cycle, is discarded.
- Counter width is clog2(TIMEOUT+1).

## Timing
- Reset (asynchronous assertion): state IDLE, `o_grant=0`, `last_owner=N_REQ-1` (so requester 0 wins the first arbitration), counter 0.
- Reset output values: `o_wb_cyc/stb/we=0`, `o_wb_addr/data=0`, `o_m_ack=0`, `o_m_err=0`, `o_m_stall` all 1.
- Grant latency: requester cyc high before edge E yields `o_grant` and `o_wb_cyc` high after E (1 cycle).
- Handoff: owner cyc sampled low at edge E gives IDLE after E; the next owner is granted at E+1. There is exactly one bus-idle cycle between owners.
- Owner throughput: none added. The pipelined `stb`/`stall`/`ack` pass combinationally, one transfer per cycle when the slave does not stall.
- Simultaneous requests: strict round-robin order after `last_owner`. A requester that keeps `cyc` high continuously waits at most N_REQ-1 ownership periods.
- Owner drops `cyc` in the same cycle as the watchdog fires: the abort takes precedence; `err` is pulsed and `last_owner` is updated identically.
- Reset asserted mid-cycle: the bus drops immediately (asynchronously); outstanding acks are not delivered.

## Test plan
- After reset, check the reset values. Requester 0 asserts cyc+stb, write addr 0xb0000010, data 0xdeadbeef, slave acks on the 2nd cycle:
  - `o_grant=01` one cycle later.
  - Slave sees the address and data.
  - `o_m_ack[0]` pulses.
  - `o_m_stall[1]` stays 1.
- Both requesters assert cyc in the same cycle after reset, each doing 1 transfer then dropping cyc:
  - Grant order is 0, then 1.
  - One idle cycle between owners.
  - A second simultaneous round is granted 1? No: after owner 1, the order restarts at 0, since `last_owner=1`.
- Requester 0 holds cyc for a 4-beat pipelined read with slave stall high on beat 2:
  - 4 acks reach requester 0, in order, with `o_m_data` matching.
  - Requester 1 (requesting throughout) is not granted until requester 0 drops cyc.
- TIMEOUT=8, slave never acks:
  - `o_m_err[0]` pulses exactly once, 8 cycles after grant.
  - `o_wb_cyc` is low in that cycle.
  - A pending requester 1 is granted next.
- Assert reset while requester 1 owns the bus mid-burst:
  - All outputs return to their reset values without a clock edge.
  - After release, requester 0 wins first.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter with whole-cycle ownership.
// A watchdog aborts an owner whose cycle receives no ack for TIMEOUT cycles.
module wb_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          i_m_cyc,
    input  logic [N_REQ-1:0]          i_m_stb,
    input  logic [N_REQ-1:0]          i_m_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_m_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_m_data,
    output logic [N_REQ-1:0]          o_m_ack,
    output logic [N_REQ-1:0]          o_m_stall,
    output logic [N_REQ-1:0]          o_m_err,
    output logic [DATA_W-1:0]         o_m_data,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_we,
    output logic [ADDR_W-1:0]         o_wb_addr,
    output logic [DATA_W-1:0]         o_wb_data,
    input  logic                      i_wb_ack,
    input  logic                      i_wb_stall,
    input  logic [DATA_W-1:0]         i_wb_data,
    output logic [N_REQ-1:0]          o_grant
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              own_cyc, own_stb, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic              found;
    logic [IW-1:0]     pick;
    logic              wd_fire;
    int                j;

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                own_cyc  = i_m_cyc[k];
                own_stb  = i_m_stb[k];
                own_we   = i_m_we[k];
                own_addr = i_m_addr[k*ADDR_W +: ADDR_W];
                own_data = i_m_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Scan starts just after the previous owner, giving round-robin order.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        j     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(last_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && i_m_cyc[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    assign wd_fire = (TIMEOUT != 0) && (state_q == BUSY) &&
                     (cnt_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BUSY;
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d         = '0;
                end
            end
            BUSY: begin
                if (wd_fire || !own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (i_wb_ack) begin
                    cnt_d = '0;
                end else if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_stall = '1;
        if (state_q == BUSY) begin
            o_wb_cyc  = own_cyc & ~wd_fire;
            o_wb_stb  = own_cyc & own_stb & ~wd_fire;
            o_wb_we   = own_we;
            o_wb_addr = own_addr;
            o_wb_data = own_data;
            for (int k = 0; k < N_REQ; k++) begin
                if (owner_q == IW'(k)) begin
                    o_m_ack[k]   = i_wb_ack & ~wd_fire;
                    o_m_stall[k] = i_wb_stall | wd_fire;
                    o_m_err[k]   = wd_fire;
                end
            end
        end
    end

    assign o_m_data = i_wb_data;
    assign o_grant  = grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single transfer, round-robin,
// pipelined burst with stall, watchdog abort and mid-cycle reset.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  i_m_cyc, i_m_stb, i_m_we;
    logic [63:0] i_m_addr, i_m_data;
    logic [1:0]  o_m_ack, o_m_stall, o_m_err;
    logic [31:0] o_m_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_ack, i_wb_stall;
    logic [31:0] i_wb_data;
    logic [1:0]  o_grant;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(
        .N_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
        .i_m_addr(i_m_addr), .i_m_data(i_m_data),
        .o_m_ack(o_m_ack), .o_m_stall(o_m_stall), .o_m_err(o_m_err),
        .o_m_data(o_m_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data), .o_grant(o_grant)
    );

    // {cyc,stb,we,ack[1:0],err[1:0],stall[1:0],grant[1:0]}
    wire [10:0] flags = {o_wb_cyc, o_wb_stb, o_wb_we, o_m_ack,
                         o_m_err, o_m_stall, o_grant};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout sim exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_m_cyc = 2'b00; i_m_stb = 2'b00; i_m_we = 2'b00;
        i_m_addr = '0; i_m_data = '0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        i_wb_data = 32'h5555_aaaa;
        #3;
        n_cmp++;
        if (flags !== 11'b000_00_00_11_00) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 11'b000_00_00_11_00);
        end
        n_cmp++;
        if ({o_wb_addr, o_wb_data} !== 64'h0) begin
            n_bad++; $display("FAIL reset_bus got=%h exp=0", {o_wb_addr, o_wb_data});
        end
        n_cmp++;
        if (o_m_data !== 32'h5555_aaaa) begin
            n_bad++; $display("FAIL m_data_pass got=%h exp=5555aaaa", o_m_data);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (o_m_ack !== 2'b00) begin
            n_bad++; $display("FAIL idle_ack_dropped got=%b exp=00", o_m_ack);
        end
        i_wb_ack = 1'b0;
        i_wb_data = '0;
    endtask

    task automatic test_single_write();
        i_m_cyc = 2'b01; i_m_stb = 2'b01; i_m_we = 2'b01;
        i_m_addr[31:0] = 32'hb000_0010;
        i_m_data[31:0] = 32'hdead_beef;
        #1;
        n_cmp++;
        if (flags !== 11'b000_00_00_11_00) begin
            n_bad++; $display("FAIL sw_pre_grant got=%b exp=%b", flags, 11'b000_00_00_11_00);
        end
        tick();
        i_wb_stall = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 11'b111_00_00_10_01) begin
            n_bad++; $display("FAIL sw_granted got=%b exp=%b", flags, 11'b111_00_00_10_01);
        end
        n_cmp++;
        if ({o_wb_addr, o_wb_data} !== 64'hb000_0010_dead_beef) begin
            n_bad++; $display("FAIL sw_addr_data got=%h exp=b0000010deadbeef", {o_wb_addr, o_wb_data});
        end
        tick();
        i_m_stb = 2'b00;
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 11'b101_01_00_10_01) begin
            n_bad++; $display("FAIL sw_ack got=%b exp=%b", flags, 11'b101_01_00_10_01);
        end
        tick();
        i_wb_ack = 1'b0; i_m_cyc = 2'b00; i_m_we = 2'b00;
        #1;
        n_cmp++;
        if (flags !== 11'b000_00_00_10_01) begin
            n_bad++; $display("FAIL sw_drop got=%b exp=%b", flags, 11'b000_00_00_10_01);
        end
        tick();
        n_cmp++;
        if (flags !== 11'b000_00_00_11_00) begin
            n_bad++; $display("FAIL sw_idle got=%b exp=%b", flags, 11'b000_00_00_11_00);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_m_cyc = 2'b11; i_m_stb = 2'b11;
        i_m_addr = {32'h2000_0004, 32'h1000_0000};
        tick();
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 11'b110_01_00_10_01 || o_wb_addr !== 32'h1000_0000) begin
            n_bad++; $display("FAIL rr_first got=%b/%h exp=%b/10000000", flags, o_wb_addr, 11'b110_01_00_10_01);
        end
        tick();
        i_wb_ack = 1'b0; i_m_cyc = 2'b10; i_m_stb = 2'b10;
        #1;
        n_cmp++;
        if (flags !== 11'b000_00_00_10_01) begin
            n_bad++; $display("FAIL rr_release0 got=%b exp=%b", flags, 11'b000_00_00_10_01);
        end
        tick();
        n_cmp++;
        if (flags !== 11'b000_00_00_11_00) begin
            n_bad++; $display("FAIL rr_gap got=%b exp=%b", flags, 11'b000_00_00_11_00);
        end
        tick();
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 11'b110_10_00_01_10 || o_wb_addr !== 32'h2000_0004) begin
            n_bad++; $display("FAIL rr_second got=%b/%h exp=%b/20000004", flags, o_wb_addr, 11'b110_10_00_01_10);
        end
        tick();
        i_wb_ack = 1'b0; i_m_cyc = 2'b00; i_m_stb = 2'b00;
        tick();
        i_m_cyc = 2'b11;
        #1;
        n_cmp++;
        if (o_grant !== 2'b00) begin
            n_bad++; $display("FAIL rr_idle2 got=%b exp=00", o_grant);
        end
        tick();
        n_cmp++;
        if (o_grant !== 2'b01) begin
            n_bad++; $display("FAIL rr_round2 got=%b exp=01", o_grant);
        end
        i_m_cyc = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [31:0] t_addr [6];
        logic        t_stb  [6];
        logic        t_stl  [6];
        logic        t_ack  [6];
        logic [31:0] exp_d  [4];
        int          acks;
        t_addr = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h10c, 32'h10c};
        t_stb  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t_stl  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t_ack  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_d  = '{32'hd000_0000, 32'hd000_0001, 32'hd000_0002, 32'hd000_0003};
        acks = 0;
        do_reset();
        i_m_cyc = 2'b11; i_m_stb = 2'b11;
        i_m_addr[31:0] = 32'h100;
        tick();
        for (int c = 0; c < 6; c++) begin
            i_m_addr[31:0] = t_addr[c];
            i_m_stb[0] = t_stb[c];
            i_wb_stall = t_stl[c];
            i_wb_ack = t_ack[c];
            i_wb_data = t_ack[c] ? exp_d[acks] : 32'h0;
            #1;
            n_cmp++;
            if (o_m_ack !== {1'b0, t_ack[c]} ||
                o_m_stall !== {1'b1, t_stl[c]} ||
                o_grant !== 2'b01 || o_wb_stb !== t_stb[c] ||
                o_wb_addr !== t_addr[c]) begin
                n_bad++;
                $display("FAIL burst_c%0d got ack=%b stall=%b grant=%b stb=%b addr=%h exp ack=%b stall=%b grant=01 stb=%b addr=%h",
                         c, o_m_ack, o_m_stall, o_grant, o_wb_stb, o_wb_addr,
                         {1'b0, t_ack[c]}, {1'b1, t_stl[c]}, t_stb[c], t_addr[c]);
            end
            if (t_ack[c]) begin
                n_cmp++;
                if (o_m_data !== exp_d[acks]) begin
                    n_bad++; $display("FAIL burst_data%0d got=%h exp=%h", acks, o_m_data, exp_d[acks]);
                end
                acks++;
            end
            tick();
        end
        i_wb_ack = 1'b0; i_m_cyc[0] = 1'b0; i_m_stb[0] = 1'b0;
        #1;
        n_cmp++;
        if (o_grant !== 2'b01 || o_wb_cyc !== 1'b0 || acks != 4) begin
            n_bad++; $display("FAIL burst_end got grant=%b cyc=%b acks=%0d exp 01/0/4", o_grant, o_wb_cyc, acks);
        end
        tick();
        n_cmp++;
        if (o_grant !== 2'b00) begin
            n_bad++; $display("FAIL burst_gap got=%b exp=00", o_grant);
        end
        tick();
        n_cmp++;
        if (o_grant !== 2'b10) begin
            n_bad++; $display("FAIL burst_next got=%b exp=10", o_grant);
        end
        i_m_cyc = 2'b00; i_m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int errs;
        errs = 0;
        do_reset();
        i_m_cyc = 2'b11; i_m_stb = 2'b11;
        tick();
        for (int c = 0; c <= 8; c++) begin
            #1;
            if (o_m_err[0]) errs++;
            n_cmp++;
            if (o_m_err !== ((c == 8) ? 2'b01 : 2'b00) ||
                o_wb_cyc !== ((c == 8) ? 1'b0 : 1'b1) ||
                o_grant !== 2'b01) begin
                n_bad++;
                $display("FAIL wd_c%0d got err=%b cyc=%b grant=%b exp err=%b cyc=%b grant=01",
                         c, o_m_err, o_wb_cyc, o_grant,
                         (c == 8) ? 2'b01 : 2'b00, (c == 8) ? 1'b0 : 1'b1);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (o_grant !== 2'b00 || o_m_err !== 2'b00) begin
            n_bad++; $display("FAIL wd_idle got grant=%b err=%b exp 00/00", o_grant, o_m_err);
        end
        tick();
        n_cmp++;
        if (o_grant !== 2'b10 || errs != 1) begin
            n_bad++; $display("FAIL wd_next got grant=%b errs=%0d exp 10/1", o_grant, errs);
        end
        i_m_cyc = 2'b00; i_m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        i_m_cyc = 2'b10; i_m_stb = 2'b10;
        i_m_addr[63:32] = 32'h3000_0000;
        i_m_data[63:32] = 32'h1234_5678;
        tick();
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 11'b110_10_00_01_10) begin
            n_bad++; $display("FAIL mid_owner1 got=%b exp=%b", flags, 11'b110_10_00_01_10);
        end
        #1;
        reset = 1'b1;
        i_m_cyc = 2'b11;
        #1;
        n_cmp++;
        if (flags !== 11'b000_00_00_11_00 || {o_wb_addr, o_wb_data} !== 64'h0) begin
            n_bad++; $display("FAIL mid_async_reset got=%b/%h exp=%b/0", flags, {o_wb_addr, o_wb_data}, 11'b000_00_00_11_00);
        end
        @(negedge clk);
        reset = 1'b0;
        i_wb_ack = 1'b0;
        tick();
        n_cmp++;
        if (o_grant !== 2'b01) begin
            n_bad++; $display("FAIL mid_first_after got=%b exp=01", o_grant);
        end
        i_m_cyc = 2'b00; i_m_stb = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst();
        test_watchdog();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
